// File: rtl/lcd_pix_unpack.sv
// lcd_pix_unpack: splits 32-bit frame-buffer words into one zero-extended
// pixel per cycle for the palette/colour-format stage.
module lcd_pix_unpack (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        lcd_en,
  input  logic        flush,
  input  logic [2:0]  bpp,
  input  logic        bebo,
  input  logic        bepo,
  input  logic [31:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [23:0] d_out_pix_ser,
  output logic        pix_valid,
  input  logic        stopin
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned PIX_W  = 24;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned BPP_W  = 3;

  localparam logic [BPP_W-1:0] BPP_1  = 3'b000;
  localparam logic [BPP_W-1:0] BPP_2  = 3'b001;
  localparam logic [BPP_W-1:0] BPP_4  = 3'b010;
  localparam logic [BPP_W-1:0] BPP_8  = 3'b011;
  localparam logic [BPP_W-1:0] BPP_24 = 3'b101;

  logic [WORD_W-1:0] hold;
  logic [BPP_W-1:0]  n_lat;
  logic              bepo_lat;
  logic [IDX_W-1:0]  idx;
  logic              loaded;

  logic [IDX_W-1:0]  last_idx_c;
  logic [IDX_W-1:0]  bit_off_c;
  logic [PIX_W-1:0]  pix_mask_c;
  logic [WORD_W-1:0] word_swap_c;
  logic              accept_c;
  logic              last_pix_c;

  // Byte reversal applied on the way into the hold register
  assign word_swap_c = bebo ? {word_data[7:0], word_data[15:8],
                               word_data[23:16], word_data[31:24]}
                            : word_data;

  assign last_pix_c = (idx == last_idx_c);
  assign word_ready = HRESETn && lcd_en && !flush &&
                      (!loaded || (last_pix_c && !stopin));
  assign accept_c   = word_valid && word_ready;
  assign pix_valid  = loaded;

  // Per-mode last pixel index, bit offset of the current pixel and its mask
  always_comb begin
    last_idx_c = 5'd1;
    bit_off_c  = {idx[0], 4'b0000};
    pix_mask_c = 24'h00FFFF;
    case (n_lat)
      BPP_1: begin
        last_idx_c = 5'd31;
        bit_off_c  = bepo_lat ? {idx[4:3], ~idx[2:0]} : idx;
        pix_mask_c = 24'h000001;
      end
      BPP_2: begin
        last_idx_c = 5'd15;
        bit_off_c  = bepo_lat ? {idx[3:2], ~idx[1:0], 1'b0} : {idx[3:0], 1'b0};
        pix_mask_c = 24'h000003;
      end
      BPP_4: begin
        last_idx_c = 5'd7;
        bit_off_c  = bepo_lat ? {idx[2:1], ~idx[0], 2'b00} : {idx[2:0], 2'b00};
        pix_mask_c = 24'h00000F;
      end
      BPP_8: begin
        last_idx_c = 5'd3;
        bit_off_c  = {idx[1:0], 3'b000};
        pix_mask_c = 24'h0000FF;
      end
      BPP_24: begin
        last_idx_c = 5'd0;
        bit_off_c  = 5'd0;
        pix_mask_c = 24'hFFFFFF;
      end
      default: begin
        last_idx_c = 5'd1;
        bit_off_c  = {idx[0], 4'b0000};
        pix_mask_c = 24'h00FFFF;
      end
    endcase
  end

  // Pixel output is forced to zero when no word is loaded
  always_comb begin
    d_out_pix_ser = '0;
    if (loaded) begin
      d_out_pix_ser = PIX_W'(hold >> bit_off_c) & pix_mask_c;
    end
  end

  // Word hold, mode latch and pixel index sequencing
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold     <= '0;
      n_lat    <= '0;
      bepo_lat <= 1'b0;
      idx      <= '0;
      loaded   <= 1'b0;
    end else if (flush || !lcd_en) begin
      loaded <= 1'b0;
      idx    <= '0;
    end else if (accept_c) begin
      hold     <= word_swap_c;
      n_lat    <= bpp;
      bepo_lat <= bepo;
      loaded   <= 1'b1;
      idx      <= '0;
    end else if (loaded && !stopin) begin
      if (!last_pix_c) begin
        idx <= idx + IDX_W'(1);
      end else begin
        loaded <= 1'b0;
        idx    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_pix_unpack.sv
// Directed bench for lcd_pix_unpack with hand-computed pixel sequences.
module tb_lcd_pix_unpack;

  logic        HCLK;
  logic        HRESETn;
  logic        lcd_en;
  logic        flush;
  logic [2:0]  bpp;
  logic        bebo;
  logic        bepo;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic [23:0] d_out_pix_ser;
  logic        pix_valid;
  logic        stopin;

  int n_checks = 0;
  int n_pass   = 0;

  lcd_pix_unpack dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .lcd_en        (lcd_en),
    .flush         (flush),
    .bpp           (bpp),
    .bebo          (bebo),
    .bepo          (bepo),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .d_out_pix_ser (d_out_pix_ser),
    .pix_valid     (pix_valid),
    .stopin        (stopin)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one cycle and settle just after the active edge
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    HRESETn = 1'b0; lcd_en = 1'b1; flush = 1'b0; bpp = 3'b011;
    bebo = 1'b0; bepo = 1'b0; word_data = '0; word_valid = 1'b0; stopin = 1'b0;

    // Reset state
    #12;
    check("rst_ready", 32'(word_ready), 32'd0);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_pix", 32'(d_out_pix_ser), 32'd0);
    #5 HRESETn = 1'b1;
    step();
    check("idle_ready", 32'(word_ready), 32'd1);
    check("idle_valid", 32'(pix_valid), 32'd0);
    check("idle_pix", 32'(d_out_pix_ser), 32'd0);

    // 8bpp with back-to-back second word
    bpp = 3'b011; word_data = 32'h4433_2211; word_valid = 1'b1;
    step();
    word_data = 32'h8877_6655;
    check("b8_p0", 32'(d_out_pix_ser), 32'h11);
    check("b8_v0", 32'(pix_valid), 32'd1);
    check("b8_rdy0", 32'(word_ready), 32'd0);
    step();
    check("b8_p1", 32'(d_out_pix_ser), 32'h22);
    step();
    check("b8_p2", 32'(d_out_pix_ser), 32'h33);
    check("b8_rdy2", 32'(word_ready), 32'd0);
    step();
    check("b8_p3", 32'(d_out_pix_ser), 32'h44);
    check("b8_rdy3", 32'(word_ready), 32'd1);
    step();
    word_valid = 1'b0;
    check("b8_w2p0", 32'(d_out_pix_ser), 32'h55);
    check("b8_w2v0", 32'(pix_valid), 32'd1);
    step();
    check("b8_w2p1", 32'(d_out_pix_ser), 32'h66);
    step();
    check("b8_w2p2", 32'(d_out_pix_ser), 32'h77);
    step();
    check("b8_w2p3", 32'(d_out_pix_ser), 32'h88);
    step();
    check("b8_end", 32'(pix_valid), 32'd0);

    // 4bpp little-endian pixel order
    bpp = 3'b010; bepo = 1'b0; word_data = 32'h0000_00A5; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    check("b4_p0", 32'(d_out_pix_ser), 32'h5);
    step();
    check("b4_p1", 32'(d_out_pix_ser), 32'hA);
    for (int k = 2; k < 8; k++) begin
      step();
      check("b4_pz", 32'(d_out_pix_ser), 32'h0);
    end
    step();
    check("b4_end", 32'(pix_valid), 32'd0);

    // 4bpp big-endian pixel order
    bepo = 1'b1; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    check("b4be_p0", 32'(d_out_pix_ser), 32'hA);
    step();
    check("b4be_p1", 32'(d_out_pix_ser), 32'h5);
    for (int k = 2; k < 8; k++) step();
    step();
    check("b4be_end", 32'(pix_valid), 32'd0);

    // 1bpp, both end bits set
    bpp = 3'b000; bepo = 1'b0; word_data = 32'h8000_0001; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      check("b1_pix", 32'(d_out_pix_ser), (k == 0 || k == 31) ? 32'd1 : 32'd0);
      step();
    end
    check("b1_end", 32'(pix_valid), 32'd0);

    // 16bpp 565 with byte swap and a stall between pixels
    bpp = 3'b110; bebo = 1'b1; word_data = 32'h1122_3344; word_valid = 1'b1;
    step();
    word_valid = 1'b0; bpp = 3'b000; bebo = 1'b0; stopin = 1'b1;
    check("b16_p0", 32'(d_out_pix_ser), 32'h002211);
    for (int k = 0; k < 3; k++) begin
      step();
      check("b16_stall", 32'(d_out_pix_ser), 32'h002211);
      check("b16_stall_rdy", 32'(word_ready), 32'd0);
    end
    stopin = 1'b0;
    step();
    check("b16_p1", 32'(d_out_pix_ser), 32'h004433);
    step();
    check("b16_end", 32'(pix_valid), 32'd0);

    // 24bpp ignores the top byte, one word per pixel
    bpp = 3'b101; word_data = 32'hFFAB_CDEF; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    check("b24_p0", 32'(d_out_pix_ser), 32'hABCDEF);
    check("b24_rdy", 32'(word_ready), 32'd1);
    step();
    check("b24_end", 32'(pix_valid), 32'd0);
    check("b24_endpix", 32'(d_out_pix_ser), 32'd0);

    // 2bpp flushed mid-word, then a fresh word restarts at pixel 0
    bpp = 3'b001; word_data = 32'h0000_00E4; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    check("b2_p0", 32'(d_out_pix_ser), 32'h0);
    step();
    check("b2_p1", 32'(d_out_pix_ser), 32'h1);
    flush = 1'b1; word_data = 32'h0000_001B; word_valid = 1'b1;
    #1;
    check("fl_rdy", 32'(word_ready), 32'd0);
    step();
    check("fl_valid", 32'(pix_valid), 32'd0);
    check("fl_pix", 32'(d_out_pix_ser), 32'd0);
    flush = 1'b0;
    step();
    word_valid = 1'b0;
    check("fl_new_p0", 32'(d_out_pix_ser), 32'h3);
    check("fl_new_v", 32'(pix_valid), 32'd1);
    step();
    check("fl_new_p1", 32'(d_out_pix_ser), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
